// File: rtl/reg_scoreboard.sv
// In-flight GPR write tracker: per-register outstanding-writer counts and long-latency pending flags.
// Optional SCB_STATS_EN builds a free-running stall cycle counter on stall_cnt.
module reg_scoreboard #(
    parameter int NREG  = 32,
    parameter int CNT_W = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        issue_fire,
    input  logic        issue_we,
    input  logic [4:0]  issue_waddr,
    input  logic        issue_long,
    input  logic        rdy_fire,
    input  logic [4:0]  rdy_waddr,
    input  logic        retire_fire,
    input  logic [4:0]  retire_waddr,
    input  logic        flush,
    input  logic [4:0]  rs1_addr,
    input  logic [4:0]  rs2_addr,
    output logic        rs1_busy,
    output logic        rs2_busy,
    output logic        stall,
    output logic        sb_err,
    output logic [31:0] stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             issue_ev;
    logic             retire_ev;
    logic [NREG-1:0]  iss_hit;
    logic [NREG-1:0]  ret_hit;
    logic [NREG-1:0]  rdy_hit;
    logic [CNT_W-1:0] cnt_q   [NREG];
    logic [CNT_W-1:0] cnt_nxt [NREG];
    logic [NREG-1:0]  long_q;
    logic [NREG-1:0]  long_nxt;
    logic             err_q;
    logic             err_set;

    assign issue_ev  = issue_fire & issue_we & (|issue_waddr);
    assign retire_ev = retire_fire & (|retire_waddr);

    // r0 is never tracked, so its hit bits stay low and its counter stays zero
    always_comb begin
        iss_hit = '0;
        ret_hit = '0;
        rdy_hit = '0;
        for (int r = 1; r < NREG; r++) begin
            iss_hit[r] = issue_ev  && (issue_waddr  == 5'(r));
            ret_hit[r] = retire_ev && (retire_waddr == 5'(r));
            rdy_hit[r] = rdy_fire  && (rdy_waddr    == 5'(r));
        end
    end

    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            cnt_nxt[r] = cnt_q[r];
        end
        long_nxt = long_q;
        err_set  = 1'b0;
        if (flush) begin
            for (int r = 0; r < NREG; r++) begin
                cnt_nxt[r] = CNT_ZERO;
            end
            long_nxt = '0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                if (iss_hit[r] && !ret_hit[r]) begin
                    if (cnt_q[r] == CNT_MAX) begin
                        err_set = 1'b1;
                    end else begin
                        cnt_nxt[r] = cnt_q[r] + CNT_ONE;
                    end
                end else if (ret_hit[r] && !iss_hit[r]) begin
                    if (cnt_q[r] == CNT_ZERO) begin
                        err_set = 1'b1;
                    end else begin
                        cnt_nxt[r] = cnt_q[r] - CNT_ONE;
                    end
                end
                // youngest issue owns the flag; otherwise data-ready, then drain-to-zero clears it
                if (iss_hit[r]) begin
                    long_nxt[r] = issue_long;
                end else if (rdy_hit[r]) begin
                    long_nxt[r] = 1'b0;
                end else if (cnt_nxt[r] == CNT_ZERO) begin
                    long_nxt[r] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= CNT_ZERO;
            end
            long_q <= '0;
            err_q  <= 1'b0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= cnt_nxt[r];
            end
            long_q <= long_nxt;
            if (err_set) begin
                err_q <= 1'b1;
            end
        end
    end

    // queries see registered state only; a producer issued this cycle is visible next cycle
    assign rs1_busy = (|rs1_addr) && (cnt_q[rs1_addr] != CNT_ZERO);
    assign rs2_busy = (|rs2_addr) && (cnt_q[rs2_addr] != CNT_ZERO);
    assign stall    = ((|rs1_addr) && long_q[rs1_addr]) || ((|rs2_addr) && long_q[rs2_addr]);
    assign sb_err   = err_q;

`ifdef SCB_STATS_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= 32'd0;
        end else if (stall && !flush) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: vector table through an expected-result queue,
// plus hand sequences for counter saturation, stall statistics and asynchronous reset.
module tb_reg_scoreboard;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        issue_fire = 1'b0, issue_we = 1'b0, issue_long = 1'b0;
    logic [4:0]  issue_waddr = 5'd0;
    logic        rdy_fire = 1'b0;
    logic [4:0]  rdy_waddr = 5'd0;
    logic        retire_fire = 1'b0;
    logic [4:0]  retire_waddr = 5'd0;
    logic        flush = 1'b0;
    logic [4:0]  rs1_addr = 5'd0, rs2_addr = 5'd0;
    logic        rs1_busy, rs2_busy, stall, sb_err;
    logic [31:0] stall_cnt;

    int total = 0;
    int bad   = 0;

    reg_scoreboard dut (
        .clk(clk), .reset(reset),
        .issue_fire(issue_fire), .issue_we(issue_we), .issue_waddr(issue_waddr), .issue_long(issue_long),
        .rdy_fire(rdy_fire), .rdy_waddr(rdy_waddr),
        .retire_fire(retire_fire), .retire_waddr(retire_waddr),
        .flush(flush), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .stall(stall), .sb_err(sb_err),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       iss;  logic [4:0] iw; logic lng;
        logic       rdy;  logic [4:0] dw;
        logic       ret;  logic [4:0] rw;
        logic       fl;   logic [4:0] a1; logic [4:0] a2;
        logic [3:0] exp;  // {rs1_busy, rs2_busy, stall, sb_err}
    } vec_t;

    vec_t       vecs [24];
    logic [3:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic logic [3:0] outs();
        return {rs1_busy, rs2_busy, stall, sb_err};
    endfunction

    task automatic clear_events();
        issue_fire = 1'b0; issue_we = 1'b0; issue_long = 1'b0; issue_waddr = 5'd0;
        rdy_fire = 1'b0; rdy_waddr = 5'd0;
        retire_fire = 1'b0; retire_waddr = 5'd0;
        flush = 1'b0;
    endtask

    // drive one cycle of events, then compare outputs just after the edge
    task automatic step(input vec_t v, input string name);
        logic [3:0] e;
        @(negedge clk);
        issue_fire = v.iss; issue_we = v.iss; issue_waddr = v.iw; issue_long = v.lng;
        rdy_fire = v.rdy; rdy_waddr = v.dw;
        retire_fire = v.ret; retire_waddr = v.rw;
        flush = v.fl; rs1_addr = v.a1; rs2_addr = v.a2;
        exp_q.push_back(v.exp);
        @(posedge clk);
        #1;
        clear_events();
        e = exp_q.pop_front();
        check(name, 32'(outs()), 32'(e));
    endtask

    function automatic vec_t mk(input logic iss, input logic [4:0] iw, input logic lng,
                                input logic rdy, input logic [4:0] dw,
                                input logic ret, input logic [4:0] rw, input logic fl,
                                input logic [4:0] a1, input logic [4:0] a2, input logic [3:0] exp);
        vec_t v;
        v.iss = iss; v.iw = iw; v.lng = lng; v.rdy = rdy; v.dw = dw;
        v.ret = ret; v.rw = rw; v.fl = fl; v.a1 = a1; v.a2 = a2; v.exp = exp;
        return v;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        clear_events();
        rs1_addr = 5'd0; rs2_addr = 5'd0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        //              iss iw    lng rdy dw   ret rw    fl  a1     a2     {b1,b2,st,err}
        vecs[0]  = mk(1, 5'd5,  0, 0, 5'd0, 0, 5'd0,  0, 5'd5,  5'd0,  4'b1000);
        vecs[1]  = mk(0, 5'd0,  0, 0, 5'd0, 1, 5'd5,  0, 5'd5,  5'd0,  4'b0000);
        vecs[2]  = mk(1, 5'd7,  1, 0, 5'd0, 0, 5'd0,  0, 5'd0,  5'd7,  4'b0110);
        vecs[3]  = mk(0, 5'd0,  0, 1, 5'd7, 0, 5'd0,  0, 5'd0,  5'd7,  4'b0100);
        vecs[4]  = mk(0, 5'd0,  0, 0, 5'd0, 0, 5'd0,  0, 5'd0,  5'd7,  4'b0100);
        vecs[5]  = mk(0, 5'd0,  0, 0, 5'd0, 1, 5'd7,  0, 5'd0,  5'd7,  4'b0000);
        vecs[6]  = mk(1, 5'd9,  0, 0, 5'd0, 0, 5'd0,  0, 5'd9,  5'd0,  4'b1000);
        vecs[7]  = mk(1, 5'd9,  0, 0, 5'd0, 1, 5'd9,  0, 5'd9,  5'd0,  4'b1000);
        vecs[8]  = mk(0, 5'd0,  0, 0, 5'd0, 1, 5'd9,  0, 5'd9,  5'd0,  4'b0000);
        vecs[9]  = mk(0, 5'd0,  0, 0, 5'd0, 1, 5'd0,  0, 5'd0,  5'd0,  4'b0000);
        vecs[10] = mk(1, 5'd4,  1, 0, 5'd0, 0, 5'd0,  0, 5'd4,  5'd6,  4'b1010);
        vecs[11] = mk(1, 5'd6,  0, 0, 5'd0, 0, 5'd0,  0, 5'd4,  5'd6,  4'b1110);
        vecs[12] = mk(1, 5'd8,  1, 0, 5'd0, 0, 5'd0,  1, 5'd4,  5'd8,  4'b0000);
        vecs[13] = mk(0, 5'd0,  0, 0, 5'd0, 0, 5'd0,  0, 5'd6,  5'd8,  4'b0000);
        vecs[14] = mk(1, 5'd10, 1, 0, 5'd0, 0, 5'd0,  0, 5'd10, 5'd0,  4'b1010);
        vecs[15] = mk(0, 5'd0,  0, 0, 5'd0, 1, 5'd10, 0, 5'd10, 5'd0,  4'b0000);
        vecs[16] = mk(0, 5'd0,  0, 0, 5'd0, 0, 5'd0,  0, 5'd10, 5'd0,  4'b0000);
        vecs[17] = mk(1, 5'd11, 1, 0, 5'd0, 0, 5'd0,  0, 5'd0,  5'd11, 4'b0110);
        vecs[18] = mk(1, 5'd11, 0, 0, 5'd0, 0, 5'd0,  0, 5'd0,  5'd11, 4'b0100);
        vecs[19] = mk(0, 5'd0,  0, 0, 5'd0, 1, 5'd11, 0, 5'd0,  5'd11, 4'b0100);
        vecs[20] = mk(0, 5'd0,  0, 0, 5'd0, 1, 5'd11, 0, 5'd0,  5'd11, 4'b0000);
        vecs[21] = mk(0, 5'd0,  0, 0, 5'd0, 1, 5'd4,  0, 5'd4,  5'd0,  4'b0001);
        vecs[22] = mk(0, 5'd0,  0, 0, 5'd0, 0, 5'd0,  1, 5'd4,  5'd0,  4'b0001);
        vecs[23] = mk(1, 5'd0,  1, 0, 5'd0, 0, 5'd0,  0, 5'd0,  5'd0,  4'b0001);

        #2;
        check("reset_outs", 32'(outs()), 32'd0);
        check("reset_stall_cnt", stall_cnt, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 24; i++) begin
            step(vecs[i], $sformatf("vec%0d", i));
        end

        // saturation: 4th issue to r3 must hold the count at 3 and flag the error
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step(mk(1, 5'd3, 0, 0, 5'd0, 0, 5'd0, 0, 5'd3, 5'd0, 4'b1000), $sformatf("ovf_issue%0d", i));
        end
        step(mk(1, 5'd3, 0, 0, 5'd0, 0, 5'd0, 0, 5'd3, 5'd0, 4'b1001), "ovf_issue3");
        step(mk(0, 5'd0, 0, 0, 5'd0, 1, 5'd3, 0, 5'd3, 5'd0, 4'b1001), "ovf_ret0");
        step(mk(0, 5'd0, 0, 0, 5'd0, 1, 5'd3, 0, 5'd3, 5'd0, 4'b1001), "ovf_ret1");
        step(mk(0, 5'd0, 0, 0, 5'd0, 1, 5'd3, 0, 5'd3, 5'd0, 4'b0001), "ovf_ret2");

        // stall statistics over a 10-cycle long hazard, then async reset mid-hold
        do_reset();
        step(mk(1, 5'd12, 1, 0, 5'd0, 0, 5'd0, 0, 5'd12, 5'd0, 4'b1010), "hold_issue");
        for (int i = 0; i < 10; i++) begin
            step(mk(0, 5'd0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd12, 5'd0, 4'b1010), $sformatf("hold%0d", i));
        end
`ifdef SCB_STATS_EN
        check("stall_cnt_10", stall_cnt, 32'd10);
`else
        check("stall_cnt_off", stall_cnt, 32'd0);
`endif
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_outs", 32'(outs()), 32'd0);
        check("async_rst_stall_cnt", stall_cnt, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        step(mk(0, 5'd0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd12, 5'd0, 4'b0000), "post_rst");
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: sim time %0t exceeded limit", $time);
        $fatal(1);
    end

endmodule
